wb_arbiter: RTL and testbench
=============================

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter: DEPTH, 2, entries per input FIFO (power of two, >=2).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 n_rst  input  1  reset, asynchronous, active-low.
REQ-004 a_valid  input  1  port A (ALU) write request valid.
REQ-005 a_ready  output  1  port A can accept; equals !fifo_a_full.
REQ-006 a_addr  input  3  port A destination register.
REQ-007 a_data  input  32  port A write data.
REQ-008 b_valid  input  1  port B (load unit) write request valid.
REQ-009 b_ready  output  1  port B can accept; equals !fifo_b_full.
REQ-010 b_addr  input  3  port B destination register.
REQ-011 b_data  input  32  port B write data.
REQ-012 we  output  1  register-file write enable, registered.
REQ-013 wa  output  3  register-file write address, registered.
REQ-014 wd  output  32  register-file write data, registered.
REQ-015 pending  output  8  bit r = 1 while any accepted write to register r is not yet committed.

Function
REQ-016 Transfer on a port SHALL occur at a rising edge with valid=1 and ready=1; data and address push into that port's FIFO.
REQ-017 valid=1 with ready=0 SHALL NOT push; requester holds.
REQ-018 Each FIFO SHALL accept a push and a pop on the same edge whenever not full; no bypass around a full FIFO.
REQ-019 Each cycle, the arbiter SHALL pop at most one entry total from the two FIFOs.
REQ-020 Arbitration SHALL be round-robin: if both non-empty, grant the port not granted last; if one non-empty, grant it; last-grant pointer updates only on a grant.
REQ-021 Grant at edge t SHALL load we=1, wa, wd from the popped entry; no grant at edge t SHALL load we=0 with wa/wd holding.
REQ-022 Latency: request accepted at edge t into an empty FIFO, no contention -> we=1 in the cycle after edge t+1.
REQ-023 Entries from one port SHALL reach we/wa/wd in acceptance order; cross-port order follows grant order.
REQ-024 Sustained throughput SHALL be one write per cycle while either FIFO is non-empty.
REQ-025 Per-register 3-bit outstanding counter: +1 per accept to that register (+2 if both ports accept the same register on one edge), -1 on each edge where we=1 and wa=r; increment and decrement on one edge net together.
REQ-026 pending[r] SHALL equal (counter[r] != 0); counters never overflow given 2*DEPTH+1 <= 7.
REQ-027 Register 0 SHALL be treated like any other register.

Reset
REQ-028 n_rst=0 SHALL asynchronously clear both FIFOs (pointers, counts), set we=0, wa=0, wd=0, pending=0, all counters 0, last-grant pointer to B (so A wins first tie).
REQ-029 During reset a_ready=b_ready=0; after release, ready=1 from the first cycle.
REQ-030 Reset mid-operation SHALL discard all queued and in-flight writes; no write is committed after assertion.

Structure
REQ-031 Shared package wb_pkg SHALL hold REG_AW=3, DATA_W=32, NREGS=8 and the FIFO entry struct {addr, data}.
REQ-032 One sub-module wb_fifo (synchronous FIFO, async active-low reset, full/empty flags) SHALL be instantiated twice.
REQ-033 Arbiter, output register and pending counters SHALL reside in wb_arbiter.

Verification
REQ-034 Single A write (addr 3, data 0xDEADBEEF) at edge 1 -> we=1, wa=3, wd=0xDEADBEEF after edge 2 only; pending[3]=1 after edge 1, 0 after edge 3.
REQ-035 A and B both valid every cycle, 4 writes each -> grants alternate A,B,A,B...; 8 consecutive we=1 cycles; per-port order preserved.
REQ-036 B held valid, never popped beyond capacity (A streaming and winning ties) -> b_ready drops after DEPTH pushes without pops; no lost or duplicated data.
REQ-037 A and B both write register 5 on the same edge -> pending[5] counter=2, clears only after the second commit.
REQ-038 n_rst asserted with both FIFOs holding entries -> we=0 immediately, pending=0; after release no stale writes appear.

Source files
------------

// File: rtl/wb_pkg.sv
// wb_pkg: shared widths, FIFO entry type and grant encoding for the write-back arbiter
package wb_pkg;
  localparam int REG_AW = 3;
  localparam int DATA_W = 32;
  localparam int NREGS  = 8;
  localparam int CNT_W  = 3;
  typedef struct packed {
    logic [REG_AW-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;
  typedef enum logic {GNT_A = 1'b0, GNT_B = 1'b1} port_e;
endpackage

// File: rtl/wb_arbiter_if.sv
// wb_arbiter_if: two write-request ports plus register-file write and pending status
interface wb_arbiter_if;
  import wb_pkg::*;
  logic              a_valid;
  logic              a_ready;
  logic [REG_AW-1:0] a_addr;
  logic [DATA_W-1:0] a_data;
  logic              b_valid;
  logic              b_ready;
  logic [REG_AW-1:0] b_addr;
  logic [DATA_W-1:0] b_data;
  logic              we;
  logic [REG_AW-1:0] wa;
  logic [DATA_W-1:0] wd;
  logic [NREGS-1:0]  pending;
  modport slave (
    input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    output a_ready, b_ready, we, wa, wd, pending
  );
  modport master (
    output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    input  a_ready, b_ready, we, wa, wd, pending
  );
endinterface

// File: rtl/wb_fifo.sv
// wb_fifo: synchronous FIFO of write entries; push is ignored when full, pop when empty
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic   clk,
  input  logic   n_rst,
  input  logic   i_push,
  input  entry_t i_din,
  input  logic   i_pop,
  output entry_t o_dout,
  output logic   o_full,
  output logic   o_empty
);
  localparam int AW = $clog2(DEPTH);
  entry_t        r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_full  = r_count == (AW+1)'(DEPTH);
  assign o_empty = r_count == '0;
  assign o_dout  = r_mem[r_rptr];
  // storage needs no reset: occupancy is tracked by the pointers
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_din;
  end
  // pointers and occupancy; power-of-two depth lets pointers wrap naturally
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: round-robin merge of two FIFO-buffered write ports into one register-file write port
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input logic         clk,
  input logic         n_rst,
  wb_arbiter_if.slave bus
);
  entry_t            w_a_in;
  entry_t            w_b_in;
  entry_t            w_a_out;
  entry_t            w_b_out;
  entry_t            w_win;
  logic              w_a_full;
  logic              w_b_full;
  logic              w_a_empty;
  logic              w_b_empty;
  logic              w_a_push;
  logic              w_b_push;
  logic              w_gnt_a;
  logic              w_gnt_b;
  port_e             r_last;
  port_e             w_last_nxt;
  logic              r_we;
  logic [REG_AW-1:0] r_wa;
  logic [DATA_W-1:0] r_wd;
  logic [CNT_W-1:0]  r_cnt     [NREGS];
  logic [CNT_W-1:0]  w_cnt_nxt [NREGS];
  logic [NREGS-1:0]  w_pend;
  assign bus.a_ready = n_rst & ~w_a_full;
  assign bus.b_ready = n_rst & ~w_b_full;
  assign w_a_push    = bus.a_valid & bus.a_ready;
  assign w_b_push    = bus.b_valid & bus.b_ready;
  assign w_a_in      = '{addr: bus.a_addr, data: bus.a_data};
  assign w_b_in      = '{addr: bus.b_addr, data: bus.b_data};
  assign bus.we      = r_we;
  assign bus.wa      = r_wa;
  assign bus.wd      = r_wd;
  assign bus.pending = w_pend;
  wb_fifo #(.DEPTH(DEPTH)) u_fifo_a (
    .clk    (clk),
    .n_rst  (n_rst),
    .i_push (w_a_push),
    .i_din  (w_a_in),
    .i_pop  (w_gnt_a),
    .o_dout (w_a_out),
    .o_full (w_a_full),
    .o_empty(w_a_empty)
  );
  wb_fifo #(.DEPTH(DEPTH)) u_fifo_b (
    .clk    (clk),
    .n_rst  (n_rst),
    .i_push (w_b_push),
    .i_din  (w_b_in),
    .i_pop  (w_gnt_b),
    .o_dout (w_b_out),
    .o_full (w_b_full),
    .o_empty(w_b_empty)
  );
  // round-robin grant: on contention the port not granted last wins
  always_comb begin
    w_gnt_a    = ~w_a_empty & (w_b_empty | (r_last == GNT_B));
    w_gnt_b    = ~w_b_empty & ~w_gnt_a;
    w_last_nxt = w_gnt_a ? GNT_A : (w_gnt_b ? GNT_B : r_last);
    w_win      = w_gnt_a ? w_a_out : w_b_out;
  end
  // last-grant register; reset to B so A wins the first tie
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) r_last <= GNT_B;
    else r_last <= w_last_nxt;
  end
  // registered write port: address/data hold when nothing is granted
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_we <= 1'b0;
      r_wa <= '0;
      r_wd <= '0;
    end else begin
      r_we <= w_gnt_a | w_gnt_b;
      if (w_gnt_a | w_gnt_b) begin
        r_wa <= w_win.addr;
        r_wd <= w_win.data;
      end
    end
  end
  // outstanding counters: accepts add, the committing write subtracts
  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      w_cnt_nxt[i] = r_cnt[i]
                   + CNT_W'(w_a_push && (bus.a_addr == REG_AW'(i)))
                   + CNT_W'(w_b_push && (bus.b_addr == REG_AW'(i)))
                   - CNT_W'(r_we && (r_wa == REG_AW'(i)));
    end
  end
  // counter state
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < NREGS; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) r_cnt[i] <= w_cnt_nxt[i];
    end
  end
  // a register is pending while its counter is non-zero
  always_comb begin
    w_pend = '0;
    for (int i = 0; i < NREGS; i++) w_pend[i] = r_cnt[i] != '0;
  end
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: randomized and directed stimulus checked against a queue-based reference model
module tb_wb_arbiter;
  localparam int DEPTH = 2;
  typedef struct {
    bit [2:0]  a;
    bit [31:0] d;
  } ent_t;
  logic clk = 1'b0;
  logic n_rst = 1'b0;
  wb_arbiter_if bus();
  wb_arbiter #(.DEPTH(DEPTH)) dut (
    .clk  (clk),
    .n_rst(n_rst),
    .bus  (bus)
  );
  always #5 clk = ~clk;
  int        n_chk = 0;
  int        n_pass = 0;
  ent_t      qa[$];
  ent_t      qb[$];
  int        cnt[8];
  bit        last_b;
  bit        ew;
  bit [2:0]  ewa;
  bit [31:0] ewd;
  bit        av, bv;
  bit [2:0]  aa, ba;
  bit [31:0] ad, bd;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    else n_pass++;
  endtask
  function automatic bit [7:0] exp_pend();
    bit [7:0] p;
    for (int r = 0; r < 8; r++) p[r] = cnt[r] != 0;
    return p;
  endfunction
  task automatic model_reset();
    qa.delete();
    qb.delete();
    for (int r = 0; r < 8; r++) cnt[r] = 0;
    last_b = 1'b1;
    ew = 1'b0;
    ewa = '0;
    ewd = '0;
  endtask
  task automatic model_edge();
    bit pa, pb, ga, gb;
    pa = av && qa.size() < DEPTH;
    pb = bv && qb.size() < DEPTH;
    ga = qa.size() != 0 && (qb.size() == 0 || last_b);
    gb = qb.size() != 0 && !ga;
    if (ew) cnt[ewa]--;
    if (ga) begin
      ew = 1; ewa = qa[0].a; ewd = qa[0].d; void'(qa.pop_front()); last_b = 0;
    end else if (gb) begin
      ew = 1; ewa = qb[0].a; ewd = qb[0].d; void'(qb.pop_front()); last_b = 1;
    end else ew = 0;
    if (pa) begin qa.push_back('{aa, ad}); cnt[aa]++; end
    if (pb) begin qb.push_back('{ba, bd}); cnt[ba]++; end
  endtask
  task automatic check_out();
    check("we", bus.we, ew);
    check("wa", bus.wa, ewa);
    check("wd", bus.wd, ewd);
    check("pending", bus.pending, exp_pend());
  endtask
  task automatic step();
    bit ra, rb;
    bus.a_valid = av; bus.a_addr = aa; bus.a_data = ad;
    bus.b_valid = bv; bus.b_addr = ba; bus.b_data = bd;
    ra = qa.size() < DEPTH;
    rb = qb.size() < DEPTH;
    #1;
    check("a_ready", bus.a_ready, ra);
    check("b_ready", bus.b_ready, rb);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_out();
    if (av && ra) av = 0;
    if (bv && rb) bv = 0;
  endtask
  task automatic new_a(input bit [2:0] a);
    av = 1; aa = a; ad = $urandom;
  endtask
  task automatic new_b(input bit [2:0] a);
    bv = 1; ba = a; bd = $urandom;
  endtask
  task automatic do_reset();
    #2;
    bus.a_valid = 1; bus.b_valid = 1;
    n_rst = 0;
    #1;
    check("rst_we", bus.we, 1'b0);
    check("rst_pending", bus.pending, 8'h0);
    check("rst_a_ready", bus.a_ready, 1'b0);
    check("rst_b_ready", bus.b_ready, 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_hold_we", bus.we, 1'b0);
    check("rst_hold_b_ready", bus.b_ready, 1'b0);
    av = 0; bv = 0;
    bus.a_valid = 0; bus.b_valid = 0;
    n_rst = 1;
  endtask
  initial begin
    int na, nb;
    av = 0; bv = 0; aa = 0; ba = 0; ad = 0; bd = 0;
    bus.a_valid = 0; bus.b_valid = 0; bus.a_addr = 0; bus.b_addr = 0;
    bus.a_data = 0; bus.b_data = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("init_we", bus.we, 1'b0);
    check("init_wa", bus.wa, 3'd0);
    check("init_wd", bus.wd, 32'd0);
    check("init_pending", bus.pending, 8'h0);
    check("init_a_ready", bus.a_ready, 1'b0);
    n_rst = 1;
    av = 1; aa = 3; ad = 32'hDEADBEEF;
    step();
    check("single_pend3", bus.pending[3], 1'b1);
    step();
    check("single_wd", bus.wd, 32'hDEADBEEF);
    step();
    check("single_clear", bus.pending[3], 1'b0);
    repeat (2) step();
    na = 0; nb = 0;
    for (int k = 0; k < 40 && (na < 4 || nb < 4 || av || bv); k++) begin
      if (!av && na < 4) begin new_a(3'(na)); na++; end
      if (!bv && nb < 4) begin new_b(3'(na + 4)); nb++; end
      step();
    end
    repeat (4) step();
    new_a(5); new_b(5);
    step();
    check("same_reg_pend5", bus.pending[5], 1'b1);
    repeat (5) step();
    for (int k = 0; k < 12; k++) begin
      if (!av) new_a(3'($urandom_range(0, 7)));
      if (!bv) new_b(3'($urandom_range(0, 7)));
      step();
    end
    do_reset();
    repeat (4) step();
    for (int k = 0; k < 400; k++) begin
      if (!av && $urandom_range(0, 99) < 55) new_a(3'($urandom_range(0, 7)));
      if (!bv && $urandom_range(0, 99) < 45) new_b(3'($urandom_range(0, 7)));
      step();
      if (k == 200) do_reset();
    end
    av = 0; bv = 0;
    repeat (8) step();
    check("drain_pending", bus.pending, 8'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
